// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - instruction fetch controller feeding the IF/ID register
//
// Optional feature macro: FETCH_BUFFER_EN
//   defined   : a response that arrives during a stall is captured in a
//               one-entry buffer.
//   undefined : that response is dropped and the same address is fetched again.
//
// Parameters:
//   RESET_PC        - PC value loaded while rst_n is low
// Ports:
//   clk             - rising-edge clock
//   rst_n           - synchronous active-low reset
//   Stall           - hazard stall, IF/ID must hold
//   Branch_Taken    - redirect request from branch resolution
//   Branch_Target   - redirect address (bits [1:0] ignored)
//   Imem_Req        - instruction-memory request
//   Imem_Addr       - instruction-memory address
//   Imem_Ready      - response valid for the current request
//   Imem_Data       - instruction word, valid with Imem_Ready
//   PC_Out          - PC for IF/ID
//   Instruction_Out - instruction for IF/ID
//   IF_ID_Write     - IF/ID load enable
//   IF_Flush        - IF/ID clear
module if_fetch_ctrl #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        Stall,
   input  logic        Branch_Taken,
   input  logic [63:0] Branch_Target,
   output logic        Imem_Req,
   output logic [63:0] Imem_Addr,
   input  logic        Imem_Ready,
   input  logic [31:0] Imem_Data,
   output logic [63:0] PC_Out,
   output logic [31:0] Instruction_Out,
   output logic        IF_ID_Write,
   output logic        IF_Flush
);

   typedef enum logic [1:0] {
      RESET_WAIT = 2'd0,
      FETCH      = 2'd1,
      HOLD       = 2'd2,
      REDIRECT   = 2'd3
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [63:0] pc;
   logic [63:0] pc_next;
   logic [63:0] branch_pc;

`ifdef FETCH_BUFFER_EN
   logic [63:0] buf_pc;
   logic [31:0] buf_data;
   logic        buf_load;
`endif

   // Redirect targets are word aligned; the low two bits are dropped.
   assign branch_pc = {Branch_Target[63:2], 2'b00};

   always_comb begin
      state_next      = state;
      pc_next         = pc;
      Imem_Req        = 1'b0;
      Imem_Addr       = 64'h0;
      PC_Out          = 64'h0;
      Instruction_Out = 32'h0;
      IF_ID_Write     = 1'b0;
      IF_Flush        = 1'b0;
`ifdef FETCH_BUFFER_EN
      buf_load        = 1'b0;
`endif

      case (state)
         RESET_WAIT: begin
            state_next = FETCH;
         end

         FETCH: begin
            Imem_Req  = 1'b1;
            Imem_Addr = pc;
            // A branch beats both a stall and any same-cycle response.
            if (Branch_Taken) begin
               IF_Flush   = 1'b1;
               pc_next    = branch_pc;
               state_next = REDIRECT;
            end else if (Imem_Ready) begin
               if (!Stall) begin
                  IF_ID_Write     = 1'b1;
                  PC_Out          = pc;
                  Instruction_Out = Imem_Data;
                  pc_next         = pc + 64'd4;
               end else begin
`ifdef FETCH_BUFFER_EN
                  buf_load   = 1'b1;
                  pc_next    = pc + 64'd4;
                  state_next = HOLD;
`endif
               end
            end
         end

         HOLD: begin
`ifdef FETCH_BUFFER_EN
            if (Branch_Taken) begin
               IF_Flush   = 1'b1;
               pc_next    = branch_pc;
               state_next = REDIRECT;
            end else if (!Stall) begin
               IF_ID_Write     = 1'b1;
               PC_Out          = buf_pc;
               Instruction_Out = buf_data;
               state_next      = FETCH;
            end
`else
            state_next = FETCH;
`endif
         end

         REDIRECT: begin
            if (Branch_Taken) begin
               IF_Flush   = 1'b1;
               pc_next    = branch_pc;
               state_next = REDIRECT;
            end else begin
               state_next = FETCH;
            end
         end

         default: begin
            state_next = RESET_WAIT;
         end
      endcase

      // While reset is held every output is quiet, whatever state is registered.
      if (!rst_n) begin
         Imem_Req        = 1'b0;
         Imem_Addr       = 64'h0;
         PC_Out          = 64'h0;
         Instruction_Out = 32'h0;
         IF_ID_Write     = 1'b0;
         IF_Flush        = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= RESET_WAIT;
         pc    <= RESET_PC;
`ifdef FETCH_BUFFER_EN
         buf_pc   <= 64'h0;
         buf_data <= 32'h0;
`endif
      end else begin
         state <= state_next;
         pc    <= pc_next;
`ifdef FETCH_BUFFER_EN
         if (buf_load) begin
            buf_pc   <= pc;
            buf_data <= Imem_Data;
         end
`endif
      end
   end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - directed self-checking bench for if_fetch_ctrl
module tb_if_fetch_ctrl;

   logic        clk;
   logic        rst_n;
   logic        Stall;
   logic        Branch_Taken;
   logic [63:0] Branch_Target;
   logic        Imem_Req;
   logic [63:0] Imem_Addr;
   logic        Imem_Ready;
   logic [31:0] Imem_Data;
   logic [63:0] PC_Out;
   logic [31:0] Instruction_Out;
   logic        IF_ID_Write;
   logic        IF_Flush;

   int compared = 0;
   int mismatched = 0;

   // {Imem_Req, IF_ID_Write, IF_Flush, Imem_Addr, PC_Out, Instruction_Out}
   logic [162:0] obs;
   logic [162:0] exp;
   assign obs = {Imem_Req, IF_ID_Write, IF_Flush, Imem_Addr, PC_Out, Instruction_Out};

   if_fetch_ctrl #(.RESET_PC(64'h100)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .Stall           (Stall),
      .Branch_Taken    (Branch_Taken),
      .Branch_Target   (Branch_Target),
      .Imem_Req        (Imem_Req),
      .Imem_Addr       (Imem_Addr),
      .Imem_Ready      (Imem_Ready),
      .Imem_Data       (Imem_Data),
      .PC_Out          (PC_Out),
      .Instruction_Out (Instruction_Out),
      .IF_ID_Write     (IF_ID_Write),
      .IF_Flush        (IF_Flush)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] d(input logic [63:0] a);
      return a[31:0] ^ 32'hA5A5_0000;
   endfunction

   // Stimulus only: branch from FETCH, pass the REDIRECT bubble, land in FETCH.
   task automatic redirect_to(input logic [63:0] tgt);
      Imem_Ready = 1'b0;
      Stall = 1'b0;
      Branch_Taken = 1'b1;
      Branch_Target = tgt;
      @(negedge clk);
      Branch_Taken = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      Imem_Ready = 1'b1;
      Imem_Data = 32'h1234_5678;
      #1;
      exp = '0;
      compared++;
      if (obs !== exp) begin mismatched++; $display("FAIL reset_before_edge got %h exp %h", obs, exp); end
      @(negedge clk);
      #1;
      compared++;
      if (obs !== exp) begin mismatched++; $display("FAIL reset_held got %h exp %h", obs, exp); end
      rst_n = 1'b1;
      #1;
      compared++;
      if (obs !== exp) begin mismatched++; $display("FAIL reset_wait got %h exp %h", obs, exp); end
      @(negedge clk);
   endtask

   task automatic test_sequential;
      for (int i = 0; i < 2; i++) begin
         logic [63:0] a;
         a = 64'h100 + 64'(4 * i);
         Imem_Ready = 1'b1;
         Imem_Data = d(a);
         #1;
         exp = {1'b1, 1'b1, 1'b0, a, a, d(a)};
         compared++;
         if (obs !== exp) begin mismatched++; $display("FAIL seq_fetch_%0d got %h exp %h", i, obs, exp); end
         @(negedge clk);
      end
   endtask

   task automatic test_stall;
      Stall = 1'b1;
      Imem_Ready = 1'b1;
      Imem_Data = d(64'h108);
`ifdef FETCH_BUFFER_EN
      #1;
      exp = {1'b1, 1'b0, 1'b0, 64'h108, 64'h0, 32'h0};
      compared++;
      if (obs !== exp) begin mismatched++; $display("FAIL stall_capture got %h exp %h", obs, exp); end
      @(negedge clk);
      Imem_Data = 32'hDEAD_BEEF;
      for (int i = 0; i < 2; i++) begin
         #1;
         exp = '0;
         compared++;
         if (obs !== exp) begin mismatched++; $display("FAIL stall_hold_%0d got %h exp %h", i, obs, exp); end
         @(negedge clk);
      end
      Stall = 1'b0;
      #1;
      exp = {1'b0, 1'b1, 1'b0, 64'h0, 64'h108, d(64'h108)};
      compared++;
      if (obs !== exp) begin mismatched++; $display("FAIL stall_release got %h exp %h", obs, exp); end
      @(negedge clk);
`else
      for (int i = 0; i < 3; i++) begin
         #1;
         exp = {1'b1, 1'b0, 1'b0, 64'h108, 64'h0, 32'h0};
         compared++;
         if (obs !== exp) begin mismatched++; $display("FAIL stall_refetch_%0d got %h exp %h", i, obs, exp); end
         @(negedge clk);
      end
      Stall = 1'b0;
      #1;
      exp = {1'b1, 1'b1, 1'b0, 64'h108, 64'h108, d(64'h108)};
      compared++;
      if (obs !== exp) begin mismatched++; $display("FAIL stall_release got %h exp %h", obs, exp); end
      @(negedge clk);
`endif
   endtask

   task automatic test_branch;
      Branch_Taken = 1'b1;
      Branch_Target = 64'h2003;
      Stall = 1'b1;
      Imem_Ready = 1'b1;
      Imem_Data = d(64'h10C);
      #1;
      exp = {1'b1, 1'b0, 1'b1, 64'h10C, 64'h0, 32'h0};
      compared++;
      if (obs !== exp) begin mismatched++; $display("FAIL branch_flush got %h exp %h", obs, exp); end
      @(negedge clk);
      Branch_Taken = 1'b0;
      Stall = 1'b0;
      #1;
      exp = '0;
      compared++;
      if (obs !== exp) begin mismatched++; $display("FAIL branch_bubble got %h exp %h", obs, exp); end
      @(negedge clk);
      Imem_Data = d(64'h2000);
      #1;
      exp = {1'b1, 1'b1, 1'b0, 64'h2000, 64'h2000, d(64'h2000)};
      compared++;
      if (obs !== exp) begin mismatched++; $display("FAIL branch_target got %h exp %h", obs, exp); end
      @(negedge clk);
   endtask

   task automatic test_rebranch;
      Imem_Ready = 1'b0;
      Branch_Taken = 1'b1;
      Branch_Target = 64'h3000;
      @(negedge clk);
      Branch_Target = 64'h41;
      #1;
      exp = {1'b0, 1'b0, 1'b1, 64'h0, 64'h0, 32'h0};
      compared++;
      if (obs !== exp) begin mismatched++; $display("FAIL rebranch_flush got %h exp %h", obs, exp); end
      @(negedge clk);
      Branch_Taken = 1'b0;
      #1;
      exp = '0;
      compared++;
      if (obs !== exp) begin mismatched++; $display("FAIL rebranch_bubble got %h exp %h", obs, exp); end
      @(negedge clk);
      #1;
      exp = {1'b1, 1'b0, 1'b0, 64'h40, 64'h0, 32'h0};
      compared++;
      if (obs !== exp) begin mismatched++; $display("FAIL rebranch_target got %h exp %h", obs, exp); end
   endtask

   task automatic test_imem_wait;
      redirect_to(64'h200);
      for (int i = 0; i < 4; i++) begin
         Imem_Ready = 1'b0;
         Imem_Data = 32'hBAD0_0000;
         #1;
         exp = {1'b1, 1'b0, 1'b0, 64'h200, 64'h0, 32'h0};
         compared++;
         if (obs !== exp) begin mismatched++; $display("FAIL wait_%0d got %h exp %h", i, obs, exp); end
         @(negedge clk);
      end
      Imem_Ready = 1'b1;
      Imem_Data = d(64'h200);
      #1;
      exp = {1'b1, 1'b1, 1'b0, 64'h200, 64'h200, d(64'h200)};
      compared++;
      if (obs !== exp) begin mismatched++; $display("FAIL wait_deliver got %h exp %h", obs, exp); end
      @(negedge clk);
      Imem_Ready = 1'b0;
      #1;
      exp = {1'b1, 1'b0, 1'b0, 64'h204, 64'h0, 32'h0};
      compared++;
      if (obs !== exp) begin mismatched++; $display("FAIL wait_next got %h exp %h", obs, exp); end
   endtask

   task automatic test_wrap;
      redirect_to(64'hFFFF_FFFF_FFFF_FFFC);
      Imem_Ready = 1'b1;
      Imem_Data = d(64'hFFFF_FFFF_FFFF_FFFC);
      #1;
      exp = {1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, d(64'hFFFF_FFFF_FFFF_FFFC)};
      compared++;
      if (obs !== exp) begin mismatched++; $display("FAIL wrap_last got %h exp %h", obs, exp); end
      @(negedge clk);
      Imem_Ready = 1'b0;
      #1;
      exp = {1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 32'h0};
      compared++;
      if (obs !== exp) begin mismatched++; $display("FAIL wrap_zero got %h exp %h", obs, exp); end
   endtask

   task automatic test_reset_mid;
      redirect_to(64'h300);
      Imem_Ready = 1'b0;
      #1;
      exp = {1'b1, 1'b0, 1'b0, 64'h300, 64'h0, 32'h0};
      compared++;
      if (obs !== exp) begin mismatched++; $display("FAIL mid_req got %h exp %h", obs, exp); end
      @(negedge clk);
      rst_n = 1'b0;
      Imem_Ready = 1'b1;
      Imem_Data = d(64'h300);
      #1;
      exp = '0;
      compared++;
      if (obs !== exp) begin mismatched++; $display("FAIL mid_reset_low got %h exp %h", obs, exp); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      compared++;
      if (obs !== exp) begin mismatched++; $display("FAIL mid_stray_ready got %h exp %h", obs, exp); end
      @(negedge clk);
      Imem_Ready = 1'b0;
      #1;
      exp = {1'b1, 1'b0, 1'b0, 64'h100, 64'h0, 32'h0};
      compared++;
      if (obs !== exp) begin mismatched++; $display("FAIL mid_restart got %h exp %h", obs, exp); end
   endtask

   initial begin
      rst_n = 1'b0;
      Stall = 1'b0;
      Branch_Taken = 1'b0;
      Branch_Target = 64'h0;
      Imem_Ready = 1'b0;
      Imem_Data = 32'h0;
      @(negedge clk);
      test_reset;
      test_sequential;
      test_stall;
      test_branch;
      test_rebranch;
      test_imem_wait;
      test_wrap;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
